// File: rtl/template_hw_pkg.sv
// ---------------------------------------------------------------------------
// template_hw_pkg
// Shared types for the template-method dispatcher and its job FIFO.
//   step_kind_e      : kind of a step command sent to the executor
//   dispatch_state_e : dispatcher FSM states
//   job_t            : default job record (payload + body-beat count)
// ---------------------------------------------------------------------------
package template_hw_pkg;

  localparam int JOB_DATA_W = 32;
  localparam int JOB_BEAT_W = 4;

  // Encodings match the step_kind port: 0=PRE, 1=BODY, 2=POST
  typedef enum logic [1:0] {
    KIND_PRE  = 2'd0,
    KIND_BODY = 2'd1,
    KIND_POST = 2'd2
  } step_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_BODY = 2'd2,
    ST_POST = 2'd3
  } dispatch_state_e;

  typedef struct packed {
    logic [JOB_DATA_W-1:0] data;
    logic [JOB_BEAT_W-1:0] beats;
  } job_t;

endpackage

// File: rtl/template_job_fifo.sv
// ---------------------------------------------------------------------------
// template_job_fifo
// DEPTH-entry synchronous FIFO of job records, asynchronous active-low reset.
// Ports:
//   clk, rst_n   : clock, async active-low reset (empties the FIFO)
//   push_i       : write request, ignored when full
//   push_data_i  : entry to write
//   full_o       : registered-occupancy full flag
//   pop_i        : read request, ignored when empty
//   head_o       : entry at the head of the queue
//   empty_o      : registered-occupancy empty flag
//   count_o      : occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module template_job_fifo
  import template_hw_pkg::*;
#(
  parameter type entry_t = job_t,
  parameter int  DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  // Full is taken from the registered count only, so a pop in the same
  // cycle never frees a slot for a push (no bypass).
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/template_job_dispatcher.sv
// ---------------------------------------------------------------------------
// template_job_dispatcher
// Buffers jobs and replays each as PRE -> BODY x beats -> POST step commands.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   job_valid/ready   : upstream job handshake (ready = FIFO not full)
//   job_data          : job payload
//   job_beats         : number of BODY steps (0 skips BODY)
//   step_valid/ready  : step command handshake to the executor
//   step_kind         : 0=PRE, 1=BODY, 2=POST
//   step_idx          : BODY beat index, 0 for PRE/POST
//   step_data         : payload, plus step_idx for BODY (wraps)
//   done              : one-cycle pulse after each POST transfer
//   busy              : FSM not idle
//   jobs_pending      : FIFO occupancy
// ---------------------------------------------------------------------------
module template_job_dispatcher
  import template_hw_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BEAT_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [DATA_W-1:0]      job_data,
  input  logic [BEAT_W-1:0]      job_beats,
  output logic                   step_valid,
  input  logic                   step_ready,
  output logic [1:0]             step_kind,
  output logic [BEAT_W-1:0]      step_idx,
  output logic [DATA_W-1:0]      step_data,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] jobs_pending
);

  // Same shape as job_t but following this instance's widths.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BEAT_W-1:0] beats;
  } job_w_t;

  dispatch_state_e   state_q, state_d;
  job_w_t            cur_q, cur_d;
  logic [BEAT_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;

  job_w_t            push_job, head_job;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic              xfer, last_beat;

  assign push_job = {job_data, job_beats};

  template_job_fifo #(
    .entry_t (job_w_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (job_valid),
    .push_data_i (push_job),
    .full_o      (fifo_full),
    .pop_i       (fifo_pop),
    .head_o      (head_job),
    .empty_o     (fifo_empty),
    .count_o     (jobs_pending)
  );

  assign job_ready = !fifo_full;
  assign done      = done_q;
  assign xfer      = step_valid && step_ready;
  assign last_beat = (idx_q == cur_q.beats - BEAT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Current-job, beat index and done-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  // Next state: a job is popped only from IDLE, so the POST transfer is
  // always followed by one IDLE cycle before the next PRE.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = head_job;
          idx_d    = '0;
          state_d  = ST_PRE;
        end
      end
      ST_PRE: begin
        if (xfer) state_d = (cur_q.beats != '0) ? ST_BODY : ST_POST;
      end
      ST_BODY: begin
        if (xfer) begin
          if (last_beat) begin
            idx_d   = '0;
            state_d = ST_POST;
          end else begin
            idx_d = idx_q + BEAT_W'(1);
          end
        end
      end
      ST_POST: begin
        if (xfer) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only; zeros while idle.
  always_comb begin
    step_valid = 1'b0;
    step_kind  = KIND_PRE;
    step_idx   = '0;
    step_data  = '0;
    busy       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_PRE: begin
        step_valid = 1'b1;
        step_kind  = KIND_PRE;
        step_data  = cur_q.data;
      end
      ST_BODY: begin
        step_valid = 1'b1;
        step_kind  = KIND_BODY;
        step_idx   = idx_q;
        step_data  = cur_q.data + DATA_W'(idx_q);
      end
      ST_POST: begin
        step_valid = 1'b1;
        step_kind  = KIND_POST;
        step_data  = cur_q.data;
      end
      default: begin
        step_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_template_job_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_template_job_dispatcher
// Directed scenarios followed by randomized traffic, compared every cycle
// against a queue-based model of accepted jobs and expanded step lists.
// ---------------------------------------------------------------------------
module tb_template_job_dispatcher;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_data;
  logic [3:0]  job_beats;
  logic        step_valid;
  logic        step_ready;
  logic [1:0]  step_kind;
  logic [3:0]  step_idx;
  logic [31:0] step_data;
  logic        done;
  logic        busy;
  logic [2:0]  jobs_pending;

  typedef struct {
    logic [31:0] data;
    int          beats;
  } jobT;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] data;
  } stepT;

  jobT  jobQ[$];
  stepT curSteps[$];
  bit   active;
  bit   doneExp;
  int   doneExpCount;
  int   doneSeen;
  int   compareCount;
  int   mismatchCount;
  int   cycle;

  template_job_dispatcher #(
    .DATA_W (32),
    .BEAT_W (4),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_data     (job_data),
    .job_beats    (job_beats),
    .step_valid   (step_valid),
    .step_ready   (step_ready),
    .step_kind    (step_kind),
    .step_idx     (step_idx),
    .step_data    (step_data),
    .done         (done),
    .busy         (busy),
    .jobs_pending (jobs_pending)
  );

  // Free-running clock, rising edge active
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s cycle %0d: observed 0x%0h, expected 0x%0h",
               tag, cycle, observed, expected);
    end
  endtask

  function automatic stepT makeStep(input int kind, input int idx, input logic [31:0] data);
    stepT s;
    s.kind = kind;
    s.idx  = idx;
    s.data = data;
    return s;
  endfunction

  // A job unrolls into its whole skeleton the moment it is started.
  task automatic expandJob(input jobT j);
    curSteps.delete();
    curSteps.push_back(makeStep(0, 0, j.data));
    for (int i = 0; i < j.beats; i++)
      curSteps.push_back(makeStep(1, i, j.data + 32'(i)));
    curSteps.push_back(makeStep(2, 0, j.data));
  endtask

  // Predicts the effect of the coming rising edge from the inputs just driven.
  task automatic modelAdvance();
    bit  acc;
    bit  nextDone;
    jobT j;
    acc      = (job_valid === 1'b1) && (jobQ.size() < DEPTH);
    nextDone = 1'b0;
    if (active) begin
      if (step_ready === 1'b1) begin
        void'(curSteps.pop_front());
        if (curSteps.size() == 0) begin
          active   = 1'b0;
          nextDone = 1'b1;
          doneExpCount++;
        end
      end
    end else if (jobQ.size() != 0) begin
      j = jobQ.pop_front();
      expandJob(j);
      active = 1'b1;
    end
    if (acc) begin
      j.data  = job_data;
      j.beats = int'(job_beats);
      jobQ.push_back(j);
    end
    doneExp = nextDone;
  endtask

  task automatic checkCycle();
    if (done === 1'b1) doneSeen++;
    checkOutput("job_ready", 32'(job_ready), 32'(jobQ.size() < DEPTH));
    checkOutput("jobs_pending", 32'(jobs_pending), 32'(jobQ.size()));
    checkOutput("step_valid", 32'(step_valid), 32'(active));
    checkOutput("busy", 32'(busy), 32'(active));
    checkOutput("done", 32'(done), 32'(doneExp));
    if (active) begin
      checkOutput("step_kind", 32'(step_kind), 32'(curSteps[0].kind));
      checkOutput("step_idx", 32'(step_idx), 32'(curSteps[0].idx));
      checkOutput("step_data", step_data, curSteps[0].data);
    end
  endtask

  task automatic checkResetZeros();
    checkOutput("rst_step_kind", 32'(step_kind), 32'd0);
    checkOutput("rst_step_idx", 32'(step_idx), 32'd0);
    checkOutput("rst_step_data", step_data, 32'd0);
  endtask

  // Drive one cycle of inputs at a falling edge, then check after the next rise.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input int b, input bit r);
    job_valid  = v;
    job_data   = d;
    job_beats  = 4'(b);
    step_ready = r;
    modelAdvance();
    @(negedge clk);
    cycle++;
    checkCycle();
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    job_valid  = 1'b0;
    step_ready = 1'b0;
    jobQ.delete();
    curSteps.delete();
    active  = 1'b0;
    doneExp = 1'b0;
    #1;
    checkCycle();
    checkResetZeros();
    @(negedge clk);
    cycle++;
    checkCycle();
    rst_n = 1'b1;
  endtask

  // Main sequence: directed scenarios, randomized traffic, drain, summary
  initial begin
    int drainBudget;
    compareCount  = 0;
    mismatchCount = 0;
    doneSeen      = 0;
    doneExpCount  = 0;
    cycle         = 0;
    active        = 1'b0;
    doneExp       = 1'b0;
    rst_n         = 1'b0;
    job_valid     = 1'b0;
    job_data      = '0;
    job_beats     = '0;
    step_ready    = 1'b0;
    repeat (2) @(negedge clk);
    checkCycle();
    checkResetZeros();
    rst_n = 1'b1;

    $display("[TB] basic job, 3 beats");
    applyStimulus(1'b1, 32'h10, 3, 1'b1);
    repeat (8) applyStimulus(1'b0, 32'h0, 0, 1'b1);

    $display("[TB] zero-beat job");
    applyStimulus(1'b1, 32'h44, 0, 1'b1);
    repeat (5) applyStimulus(1'b0, 32'h0, 0, 1'b1);

    $display("[TB] stall during BODY idx1");
    applyStimulus(1'b1, 32'h20, 4, 1'b1);
    repeat (3) applyStimulus(1'b0, 32'h0, 0, 1'b1);
    checkOutput("stall_idx", 32'(step_idx), 32'd1);
    repeat (5) applyStimulus(1'b0, 32'h0, 0, 1'b0);
    repeat (8) applyStimulus(1'b0, 32'h0, 0, 1'b1);

    $display("[TB] fill FIFO with executor stalled");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 32'h100 + 32'(i), i % 3, 1'b0);
    checkOutput("pending_full", 32'(jobs_pending), 32'd4);
    checkOutput("ready_full", 32'(job_ready), 32'd0);
    repeat (40) applyStimulus(1'b0, 32'h0, 0, 1'b1);

    $display("[TB] data wrap");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 2, 1'b1);
    repeat (7) applyStimulus(1'b0, 32'h0, 0, 1'b1);

    $display("[TB] reset mid-BODY");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h200 + 32'(i), 4, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 0, 1'b1);
    checkOutput("midbody_pending", 32'(jobs_pending), 32'd2);
    doReset();
    repeat (6) applyStimulus(1'b0, 32'h0, 0, 1'b1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset();
      end else begin
        applyStimulus(($urandom_range(0, 99) < 40), $urandom(),
                      ($urandom_range(0, 99) < 10) ? 15 : int'($urandom_range(0, 4)),
                      ($urandom_range(0, 99) < 70));
      end
    end

    drainBudget = 0;
    while ((active || jobQ.size() != 0 || doneExp) && drainBudget < 300) begin
      applyStimulus(1'b0, 32'h0, 0, 1'b1);
      drainBudget++;
    end
    applyStimulus(1'b0, 32'h0, 0, 1'b1);
    checkOutput("drain_idle", 32'(busy), 32'd0);
    checkOutput("done_total", 32'(doneSeen), 32'(doneExpCount));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
